seq_pattern_gen: RTL and testbench

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

---
 rtl/seq_gen_pkg.sv | 18 +
 rtl/seq_shift_reg.sv | 31 +++
 rtl/seq_pattern_gen.sv | 174 +++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared constants and FSM state encoding for the serial pattern generator.
// Macro SEQ_GEN_GAP_EN adds the GAP state used between repetitions.
package seq_gen_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
`ifdef SEQ_GEN_GAP_EN
        ,
        GAP   = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, shift-left register; the MSB is the serial output bit.
// Load has priority over shift.
module seq_shift_reg #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [PAT_W-1:0] i_data,
    output logic             o_msb
);

    logic [PAT_W-1:0] r_q;

    // Shift register storage: load, shift left with zero fill, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= {PAT_W{1'b0}};
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= {r_q[PAT_W-2:0], 1'b0};
        end else begin
            r_q <= r_q;
        end
    end

    assign o_msb = r_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: emits a latched pattern MSB first, reps times.
// Define SEQ_GEN_GAP_EN to insert one idle GAP cycle between repetitions.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W    = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] REPS_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PAT_W-1:0] r_pat;
    logic [CNT_W-1:0] r_reps_left;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_load;
    logic [PAT_W-1:0] w_load_data;
    logic             w_shift;
    logic             w_idx_clr;
    logic             w_idx_inc;
    logic             w_rep_dec;
    logic             w_msb;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control. Loading zero on the way out of SHIFT
    // keeps x low whenever valid is low, without gating the output.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_load_data = {PAT_W{1'b0}};
        w_shift     = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_rep_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept  = 1'b1;
                    w_idx_clr = 1'b1;
                    if (reps == {CNT_W{1'b0}}) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = SHIFT;
                        w_load      = 1'b1;
                        w_load_data = pattern;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (r_idx == IDX_LAST) begin
                    w_rep_dec = 1'b1;
                    w_idx_clr = 1'b1;
                    w_load    = 1'b1;
                    if (r_reps_left == REPS_ONE) begin
                        w_state_nxt = DONE;
                        w_load_data = {PAT_W{1'b0}};
                    end else begin
`ifdef SEQ_GEN_GAP_EN
                        w_state_nxt = GAP;
                        w_load_data = {PAT_W{1'b0}};
`else
                        w_state_nxt = SHIFT;
                        w_load_data = r_pat;
`endif
                    end
                end else begin
                    w_shift   = 1'b1;
                    w_idx_inc = 1'b1;
                end
            end
`ifdef SEQ_GEN_GAP_EN
            GAP: begin
                w_state_nxt = SHIFT;
                w_load      = 1'b1;
                w_load_data = r_pat;
            end
`endif
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Latched burst parameters and remaining-repetition counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat       <= {PAT_W{1'b0}};
            r_reps_left <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_pat       <= pattern;
            r_reps_left <= reps;
        end else if (w_rep_dec) begin
            r_reps_left <= r_reps_left - REPS_ONE;
        end else begin
            r_reps_left <= r_reps_left;
        end
    end

    // Bit-index counter within the current repetition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= {IDX_W{1'b0}};
        end else if (w_idx_clr) begin
            r_idx <= {IDX_W{1'b0}};
        end else if (w_idx_inc) begin
            r_idx <= r_idx + IDX_ONE;
        end else begin
            r_idx <= r_idx;
        end
    end

    // Status outputs registered from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= (w_state_nxt == SHIFT);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    seq_shift_reg #(
        .PAT_W (PAT_W)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_load_data),
        .o_msb   (w_msb)
    );

    assign x     = w_msb;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: stimulus pushes per-cycle expected
// {valid,x,busy,done} vectors; a negedge monitor pops and compares them.
module tb_seq_pattern_gen;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
`ifdef SEQ_GEN_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        mon_en   = 1'b0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;

    seq_pattern_gen #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .reps    (reps),
        .x       (x),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: {valid,x,busy,done} got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic push(input logic v, input logic xb, input logic b, input logic d);
        exp_q.push_back({v, xb, b, d});
    endtask

    // Pre-accept idle cycle, the pattern bits (with optional gaps), then DONE.
    task automatic push_burst(input logic [PAT_W-1:0] p, input int n);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < n; r++) begin
            for (int i = PAT_W - 1; i >= 0; i--) begin
                push(1'b1, p[i], 1'b1, 1'b0);
            end
            if (GAP_ON && (r < n - 1)) begin
                push(1'b0, 1'b0, 1'b1, 1'b0);
            end
        end
        push(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic wait_drain(input int limit);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: %0d expected vectors left, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_simple(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] n);
        start   = 1'b1;
        pattern = p;
        reps    = n;
        push_burst(p, int'(n));
        @(posedge clk);
        #1;
        start   = 1'b0;
        pattern = ~p;
        reps    = n + 8'd7;
        wait_drain(3000);
    endtask

    // Monitor: any cycle not covered by an expectation must be fully quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("trace", {valid, x, busy, done}, mon_exp);
            end else begin
                check("quiet", {valid, x, busy, done}, 4'b0000);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        pattern = 4'b0000;
        reps    = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Release reset with start already high: accepted at the first edge.
        rst = 1'b0;
        run_simple(4'b1010, 8'd3);
        run_simple(4'b1010, 8'd2);
        run_simple(4'b1111, 8'd0);
        run_simple(4'b0111, 8'd1);
        run_simple(4'b1001, 8'd255);

        // Start and new pattern during the burst must be ignored.
        start   = 1'b1;
        pattern = 4'b1100;
        reps    = 8'd2;
        push_burst(4'b1100, 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start   = 1'b1;
        pattern = 4'b0011;
        reps    = 8'd7;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain(100);

        // Asynchronous reset in the middle of repetition 2.
        start   = 1'b1;
        pattern = 4'b1010;
        reps    = 8'd5;
        push_burst(4'b1010, 5);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset", {valid, x, busy, done}, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_simple(4'b1010, 8'd1);

        // start held high: three back-to-back bursts, then released.
        start   = 1'b1;
        pattern = 4'b0110;
        reps    = 8'd1;
        for (int k = 0; k < 3; k++) begin
            push_burst(4'b0110, 1);
        end
        repeat (13) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain(100);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
